mod_updown_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, parallel load, synchronous clear and wrap-or-saturate overflow mode. It replaces the fixed 4-bit free-running up counter wherever a design needs a bounded range, direction control, preset values or event flags. Examples are timers, address generators and event counters. With default parameters and `en=1`, `up=1`, it counts 0..15 and wraps.

---
 rtl/mod_updown_counter_pkg.sv | 20 ++
 rtl/mod_updown_counter_cnt_next_val.sv | 39 +++
 rtl/mod_updown_counter.sv | 86 ++++++++
 tb/tb_mod_updown_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and parameter-range helpers for the up/down counter family.
package counter_pkg;

    // Overflow behaviour selectors for the SATURATE parameter.
    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // Counter width must fit the 1..32 bit range.
    function automatic bit width_ok(input int w);
        return (w >= 1) && (w <= 32);
    endfunction

    // Top of range must be non-zero and representable in w bits.
    function automatic bit max_ok(input int w, input longint m);
        longint limit;
        limit = (longint'(1) << w) - longint'(1);
        return (m >= 1) && (m <= limit);
    endfunction

endpackage

// File: rtl/mod_updown_counter_cnt_next_val.sv
// Combinational next-count computation with explicit bound detection.
module cnt_next_val
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_V    = 4'd15,
    parameter int               SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] next_o,
    output logic             bound_hit_o
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    // Bounds are compared before any add/subtract so the result never depends on WIDTH-bit rollover.
    always_comb begin
        next_o      = count_i;
        bound_hit_o = 1'b0;
        if (up_i) begin
            if (count_i >= MAX_V) begin
                bound_hit_o = 1'b1;
                next_o      = (SATURATE == CNT_MODE_SAT) ? MAX_V : ZERO;
            end else begin
                next_o = count_i + ONE;
            end
        end else begin
            if (count_i == ZERO) begin
                bound_hit_o = 1'b1;
                next_o      = (SATURATE == CNT_MODE_SAT) ? ZERO : MAX_V;
            end else begin
                next_o = count_i - ONE;
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter: programmable modulus, parallel load,
// synchronous clear, wrap or saturate at the bounds, pulse and sticky flags.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH     = 4,
    parameter longint MAX_COUNT = 15,
    parameter int     SATURATE  = CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             ovf_sticky
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be in 1..32");
    end
    if (!max_ok(WIDTH, MAX_COUNT)) begin : g_bad_max
        $error("mod_updown_counter: MAX_COUNT must be in 1..2^WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] step_val;
    logic             bound_hit;

    cnt_next_val #(
        .WIDTH    (WIDTH),
        .MAX_V    (MAX_V),
        .SATURATE (SATURATE)
    ) u_next (
        .count_i     (count_q),
        .up_i        (up),
        .next_o      (step_val),
        .bound_hit_o (bound_hit)
    );

    // Priority mux: clear > load > count enable > hold (reset handled in the register).
    always_comb begin
        count_d  = count_q;
        wrap_d   = 1'b0;
        sticky_d = sticky_q;
        if (clear) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            count_d  = step_val;
            wrap_d   = bound_hit;
            sticky_d = sticky_q | bound_hit;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            sticky_q <= sticky_d;
        end
    end

    assign count      = count_q;
    assign wrap       = wrap_q;
    assign ovf_sticky = sticky_q;
    assign at_max     = (count_q == MAX_V);
    assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter across four parameter sets:
// 0: W4/MAX15/wrap, 1: W4/MAX9/wrap, 2: W4/MAX9/sat, 3: W8/MAX255/wrap.
module tb_mod_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a [4];
    logic       clr_a [4];
    logic       ld_a  [4];
    logic [7:0] lv_a  [4];
    logic       en_a  [4];
    logic       up_a  [4];

    logic [7:0] cnt_a [4];
    logic       amx_a [4];
    logic       az_a  [4];
    logic       wr_a  [4];
    logic       st_a  [4];

    logic [3:0] c0, c1, c2;
    logic [7:0] c3;

    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0)) u0 (
        .clk(clk), .reset(rst_a[0]), .clear(clr_a[0]), .load(ld_a[0]), .load_val(lv_a[0][3:0]),
        .en(en_a[0]), .up(up_a[0]), .count(c0), .at_max(amx_a[0]), .at_zero(az_a[0]),
        .wrap(wr_a[0]), .ovf_sticky(st_a[0]));
    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) u1 (
        .clk(clk), .reset(rst_a[1]), .clear(clr_a[1]), .load(ld_a[1]), .load_val(lv_a[1][3:0]),
        .en(en_a[1]), .up(up_a[1]), .count(c1), .at_max(amx_a[1]), .at_zero(az_a[1]),
        .wrap(wr_a[1]), .ovf_sticky(st_a[1]));
    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) u2 (
        .clk(clk), .reset(rst_a[2]), .clear(clr_a[2]), .load(ld_a[2]), .load_val(lv_a[2][3:0]),
        .en(en_a[2]), .up(up_a[2]), .count(c2), .at_max(amx_a[2]), .at_zero(az_a[2]),
        .wrap(wr_a[2]), .ovf_sticky(st_a[2]));
    mod_updown_counter #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(0)) u3 (
        .clk(clk), .reset(rst_a[3]), .clear(clr_a[3]), .load(ld_a[3]), .load_val(lv_a[3]),
        .en(en_a[3]), .up(up_a[3]), .count(c3), .at_max(amx_a[3]), .at_zero(az_a[3]),
        .wrap(wr_a[3]), .ovf_sticky(st_a[3]));

    assign cnt_a[0] = {4'b0, c0};
    assign cnt_a[1] = {4'b0, c1};
    assign cnt_a[2] = {4'b0, c2};
    assign cnt_a[3] = c3;

    typedef struct {
        int       d;
        bit       r, c, l;
        bit [7:0] v;
        bit       e, u;
        int       cnt;
        bit       wr, st, amx, az;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got %0d, expected %0d", name, d, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int d, input int cnt,
                           input bit wr, input bit st, input bit amx, input bit az);
        chk({tag, " count"},      d, int'(cnt_a[d]), cnt);
        chk({tag, " wrap"},       d, int'(wr_a[d]),  int'(wr));
        chk({tag, " ovf_sticky"}, d, int'(st_a[d]),  int'(st));
        chk({tag, " at_max"},     d, int'(amx_a[d]), int'(amx));
        chk({tag, " at_zero"},    d, int'(az_a[d]),  int'(az));
    endtask

    // Drive one instance for one clock edge; all other instances idle and hold.
    task automatic step(input int d, input bit r, input bit c, input bit l,
                        input bit [7:0] v, input bit e, input bit u);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rst_a[i] = 1'b0; clr_a[i] = 1'b0; ld_a[i] = 1'b0; en_a[i] = 1'b0;
        end
        rst_a[d] = r; clr_a[d] = c; ld_a[d] = l; lv_a[d] = v; en_a[d] = e; up_a[d] = u;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input int d, input bit r, input bit c, input bit l,
                                input bit [7:0] v, input bit e, input bit u, input int cnt,
                                input bit wr, input bit st, input bit amx, input bit az);
        vec_t t;
        t.d = d; t.r = r; t.c = c; t.l = l; t.v = v; t.e = e; t.u = u;
        t.cnt = cnt; t.wr = wr; t.st = st; t.amx = amx; t.az = az;
        vq.push_back(t);
    endfunction

    initial begin
        //  d  r  c  l   v   e  u   cnt wr st mx az
        // MAX=9 wrap: down from 0 wraps to 9, then counts down
        add(1, 0, 0, 0,   0, 1, 0,   9, 1, 1, 1, 0);
        add(1, 0, 0, 0,   0, 1, 0,   8, 0, 1, 0, 0);
        add(1, 0, 0, 0,   0, 1, 0,   7, 0, 1, 0, 0);
        // load above MAX clamps, no wrap, sticky unchanged, en ignored
        add(1, 0, 0, 1,  12, 1, 1,   9, 0, 1, 1, 0);
        // clear beats load and en
        add(1, 0, 1, 1,   5, 1, 1,   0, 0, 0, 0, 1);
        // re-arm sticky, then reset beats load
        add(1, 0, 0, 0,   0, 1, 0,   9, 1, 1, 1, 0);
        add(1, 1, 0, 1,   5, 1, 1,   0, 0, 0, 0, 1);
        // hold at 7 for 5 cycles, then toggle direction
        add(1, 0, 0, 1,   7, 0, 0,   7, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(1, 0, 0, 0, 0, 0, k[0], 7, 0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 1, 1,   8, 0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 1, 0,   7, 0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 1, 1,   8, 0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 1, 0,   7, 0, 0, 0, 0);
        // W=8 full range: 254, 255, 0 with wrap
        add(3, 0, 0, 1, 254, 0, 1, 254, 0, 0, 0, 0);
        add(3, 0, 0, 0,   0, 1, 1, 255, 0, 0, 1, 0);
        add(3, 0, 0, 0,   0, 1, 1,   0, 1, 1, 0, 1);
        // load with en=1 does not count; then reset mid-count at 100
        add(3, 0, 0, 1,  99, 1, 1,  99, 0, 1, 0, 0);
        add(3, 0, 0, 0,   0, 1, 1, 100, 0, 1, 0, 0);
        add(3, 1, 0, 0,   0, 1, 1,   0, 0, 0, 0, 1);
        // saturate: load 8, then up three times -> 9, 9, 9
        add(2, 0, 0, 1,   8, 1, 1,   8, 0, 0, 0, 0);
        add(2, 0, 0, 0,   0, 1, 1,   9, 0, 0, 1, 0);
        add(2, 0, 0, 0,   0, 1, 1,   9, 1, 1, 1, 0);
        add(2, 0, 0, 0,   0, 1, 1,   9, 1, 1, 1, 0);

        for (int i = 0; i < 4; i++) begin
            rst_a[i] = 1'b1; clr_a[i] = 1'b0; ld_a[i] = 1'b0;
            lv_a[i] = 8'd0; en_a[i] = 1'b0; up_a[i] = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk_all("reset", i, 0, 0, 0, 0, 1);

        // Default set: 17 up-counts give 1..15, 0, 1 with a single wrap at 15->0
        for (int k = 0; k < 17; k++) begin
            int exp_c;
            exp_c = (k + 1) % 16;
            step(0, 0, 0, 0, 0, 1, 1);
            chk_all("free-run", 0, exp_c, k == 15, k >= 15, exp_c == 15, exp_c == 0);
        end

        foreach (vq[i]) begin
            step(vq[i].d, vq[i].r, vq[i].c, vq[i].l, vq[i].v, vq[i].e, vq[i].u);
            chk_all($sformatf("vec%0d", i), vq[i].d, vq[i].cnt, vq[i].wr, vq[i].st,
                    vq[i].amx, vq[i].az);
        end

        // Saturate: down from 9 reaches 0 after 9 edges, then holds with wrap pulses
        for (int k = 0; k < 11; k++) begin
            int exp_c;
            exp_c = (k < 9) ? (8 - k) : 0;
            step(2, 0, 0, 0, 0, 1, 0);
            chk_all("sat-down", 2, exp_c, k >= 9, 1, 0, exp_c == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
